branch_update: RTL and testbench
================================

BRANCH_UPDATE -- requirements
Module: branch_update

Interface
REQ-001 SHALL have parameter DEPTH, default 4, prediction-queue depth (power of two).
REQ-002 SHALL have parameter CNT_ENTRIES, default 8, number of 2-bit counters, indexed by pc[2:0].
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pred_push  input  1  fetch issued a branch lookup.
REQ-006 SHALL have port pred_pc  input  ADDR_WIDTH  pc looked up.
REQ-007 SHALL have port pred_target  input  ADDR_WIDTH  target returned by the target buffer.
REQ-008 SHALL have port pred_taken  input  1  target buffer valid/hit at lookup.
REQ-009 SHALL have port pred_ready  output  1  queue can accept a push.
REQ-010 SHALL have port res_valid  input  1  execute resolved the oldest outstanding branch.
REQ-011 SHALL have port res_taken  input  1  actual direction.
REQ-012 SHALL have port res_target  input  ADDR_WIDTH  actual target.
REQ-013 SHALL have ports btb_write (output, 1), btb_key (output, ADDR_WIDTH), btb_val (output, ADDR_WIDTH) and btb_hit (output, 1), which together form the update to the target buffer.
REQ-014 SHALL have port flush  output  1  one-cycle mispredict flush.
REQ-015 SHALL have port redirect  output  ADDR_WIDTH  correct fetch pc, valid when flush=1.
REQ-016 SHALL have port err  output  1  sticky underflow flag.

Function
REQ-017 SHALL hold an in-order FIFO of DEPTH entries {pc, target, taken}, a (log2 DEPTH + 1)-bit count, and wrapping read/write pointers.
REQ-018 SHALL drive pred_ready = (count < DEPTH), computed from registered count only; a push while full is dropped even if a pop occurs in the same cycle.
REQ-019 SHALL accept a push on a rising edge when pred_push and pred_ready are both high.
REQ-020 SHALL pop the head entry on a rising edge when res_valid=1 and count>0; a simultaneous push and pop leaves count unchanged.
REQ-021 SHALL define a mispredict as (res_taken != head.taken) or (res_taken and head.taken and res_target != head.target).
REQ-022 SHALL update the counter at head.pc[2:0] on each pop: saturating increment (max 3) if taken, saturating decrement (min 0) if not taken.
REQ-023 SHALL register all update outputs one cycle after the pop edge.
REQ-024 SHALL assert btb_write for one cycle when res_taken or head.taken.
REQ-025 SHALL drive btb_key = head.pc on a btb_write.
REQ-026 SHALL drive btb_val = res_taken ? res_target : head.target on a btb_write.
REQ-027 SHALL drive btb_hit = bit 1 of the updated counter on a btb_write.
REQ-028 SHALL assert flush for one cycle on a mispredict, with redirect = res_taken ? res_target : head.pc + 1 (word-addressed, modulo 2^ADDR_WIDTH).
REQ-029 SHALL, on the mispredict edge, set count and both pointers to 0 and discard any push in that cycle.
REQ-030 SHALL, when res_valid=1 and count=0, ignore the resolve, make no counter change, produce no outputs, and set err=1 until reset.
REQ-031 SHALL hold btb_write and flush at 0 in every cycle without a qualifying pop; btb_key, btb_val, btb_hit and redirect hold their last values.

Reset
REQ-032 SHALL, while reset=0, asynchronously clear count and pointers and drive btb_write, btb_hit, flush and err to 0 and btb_key, btb_val and redirect to 0.
REQ-033 SHALL reset all counters to 2'b01 (weakly not-taken) and clear FIFO contents.
REQ-034 SHALL, when reset is asserted mid-operation, abandon any pending registered update output, and SHALL accept the first push on the first rising edge after reset deasserts.

Structure
REQ-035 SHALL take ADDR_WIDTH and the counter constants (CNT_INIT=2'b01, CNT_MAX=2'b11) from the shared defines.vh.
REQ-036 SHALL implement the queue as one sub-module, pred_fifo (push/pop/count/full/empty, async active-low reset); counters and compare logic stay in branch_update.

Verification
REQ-037 SHALL verify: push {pc=0x10, tgt=0x40, taken=1}; resolve taken to 0x40 -> next cycle btb_write=1, key=0x10, val=0x40, hit=1 (counter 1->2), flush=0.
REQ-038 SHALL verify: push {0x20, 0x00, taken=0}; resolve taken to 0x80 -> flush=1, redirect=0x80, btb_write=1, val=0x80, hit=1, count=0.
REQ-039 SHALL verify: push {0x30, 0x50, taken=1}; resolve not taken -> flush=1, redirect=0x31, btb_write=1, val=0x50, hit=0 (counter 1->0).
REQ-040 SHALL verify: 4 pushes -> pred_ready=0; a 5th push with a simultaneous pop -> count stays 3 after the pop, and the 5th entry is absent.
REQ-041 SHALL verify: res_valid with an empty queue -> no btb_write, no flush, err=1 until reset=0.
REQ-042 SHALL verify: taken resolves on pc=0x18 three times -> btb_hit sequence 1, 1, 1 (counter saturates at 3); then reset=0 mid-stream -> all outputs 0 asynchronously, and the counter returns to 01.

Source files
------------

// File: rtl/branch_update_pkg.sv
// branch_update_pkg: shared address width, counter constants and prediction-queue entry type
package branch_update_pkg;
    localparam int ADDR_WIDTH = 16;
    localparam logic [1:0] CNT_INIT = 2'b01;
    localparam logic [1:0] CNT_MAX = 2'b11;
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] target;
        logic taken;
    } pred_entry_t;
    function automatic logic [1:0] cnt_next(input logic [1:0] c, input logic taken);
        return taken ? (c == CNT_MAX ? CNT_MAX : c + 2'd1) : (c == 2'd0 ? 2'd0 : c - 2'd1);
    endfunction
endpackage

// File: rtl/pred_fifo.sv
// pred_fifo: in-order queue of outstanding branch predictions; clear empties it and drops any push
module pred_fifo
    import branch_update_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  pred_entry_t din,
    output pred_entry_t dout,
    output logic        full,
    output logic        empty
);
    pred_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            count <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            count <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (do_push) mem[wr_ptr] <= din;
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/branch_update.sv
// branch_update: resolves queued predictions against execute results, trains 2-bit counters,
// and emits target-buffer updates and mispredict flushes one cycle after each pop
module branch_update
    import branch_update_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_ENTRIES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pred_push,
    input  logic [ADDR_WIDTH-1:0] pred_pc,
    input  logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  pred_taken,
    output logic                  pred_ready,
    input  logic                  res_valid,
    input  logic                  res_taken,
    input  logic [ADDR_WIDTH-1:0] res_target,
    output logic                  btb_write,
    output logic [ADDR_WIDTH-1:0] btb_key,
    output logic [ADDR_WIDTH-1:0] btb_val,
    output logic                  btb_hit,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] redirect,
    output logic                  err
);
    localparam int IW = $clog2(CNT_ENTRIES);
    pred_entry_t din, head;
    logic full, empty, pop, mispredict, upd_write;
    logic [IW-1:0] idx;
    logic [1:0] cnt [CNT_ENTRIES];
    logic [1:0] cnt_upd;
    assign din = '{pc: pred_pc, target: pred_target, taken: pred_taken};
    assign pred_ready = !full;
    assign pop = res_valid && !empty;
    assign mispredict = (res_taken != head.taken) || (res_taken && res_target != head.target);
    assign upd_write = res_taken || head.taken;
    assign idx = head.pc[IW-1:0];
    assign cnt_upd = cnt_next(cnt[idx], res_taken);
    pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(pred_push),
        .pop(res_valid),
        .clear(pop && mispredict),
        .din(din),
        .dout(head),
        .full(full),
        .empty(empty)
    );
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            for (int i = 0; i < CNT_ENTRIES; i++) cnt[i] <= CNT_INIT;
            btb_write <= 1'b0;
            btb_key <= '0;
            btb_val <= '0;
            btb_hit <= 1'b0;
            flush <= 1'b0;
            redirect <= '0;
            err <= 1'b0;
        end else begin
            btb_write <= pop && upd_write;
            flush <= pop && mispredict;
            err <= err || (res_valid && empty);
            if (pop) cnt[idx] <= cnt_upd;
            if (pop && upd_write) begin
                btb_key <= head.pc;
                btb_val <= res_taken ? res_target : head.target;
                btb_hit <= cnt_upd[1];
            end
            if (pop && mispredict) redirect <= res_taken ? res_target : head.pc + 1'b1;
        end
endmodule

// File: tb/tb_branch_update.sv
// tb_branch_update: directed vector table plus hand-written multi-cycle sequences for branch_update
module tb_branch_update;
    import branch_update_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic pred_push = 1'b0, pred_taken = 1'b0, pred_ready;
    logic [ADDR_WIDTH-1:0] pred_pc = '0, pred_target = '0;
    logic res_valid = 1'b0, res_taken = 1'b0;
    logic [ADDR_WIDTH-1:0] res_target = '0;
    logic btb_write, btb_hit, flush, err;
    logic [ADDR_WIDTH-1:0] btb_key, btb_val, redirect;
    int checks = 0;
    int failures = 0;

    branch_update dut (
        .clk(clk), .reset(reset),
        .pred_push(pred_push), .pred_pc(pred_pc), .pred_target(pred_target),
        .pred_taken(pred_taken), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .btb_write(btb_write), .btb_key(btb_key), .btb_val(btb_val), .btb_hit(btb_hit),
        .flush(flush), .redirect(redirect), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc, tgt;
        logic ptk, rtk;
        logic [15:0] rtgt;
        logic w;
        logic [15:0] k, v;
        logic h, f;
        logic [15:0] r;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        pred_push = 1'b0;
        res_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic set_push(input logic [15:0] pc, input logic [15:0] tgt, input logic tk);
        pred_push = 1'b1;
        pred_pc = pc;
        pred_target = tgt;
        pred_taken = tk;
    endtask

    task automatic set_res(input logic tk, input logic [15:0] tgt);
        res_valid = 1'b1;
        res_taken = tk;
        res_target = tgt;
    endtask

    task automatic step();
        @(negedge clk);
        pred_push = 1'b0;
        res_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h0010, 16'h0040, 1'b1, 1'b1, 16'h0040, 1'b1, 16'h0010, 16'h0040, 1'b1, 1'b0, 16'h0000};
        vecs[1] = '{16'h0020, 16'h0000, 1'b0, 1'b1, 16'h0080, 1'b1, 16'h0020, 16'h0080, 1'b1, 1'b1, 16'h0080};
        vecs[2] = '{16'h0030, 16'h0050, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0030, 16'h0050, 1'b0, 1'b1, 16'h0031};
        vecs[3] = '{16'h0007, 16'h0020, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[4] = '{16'h0011, 16'h0040, 1'b1, 1'b1, 16'h0044, 1'b1, 16'h0011, 16'h0044, 1'b1, 1'b1, 16'h0044};
        vecs[5] = '{16'hFFFF, 16'h0010, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 16'h0010, 1'b0, 1'b1, 16'h0000};

        @(negedge clk);
        chk("rst_ready", pred_ready, 1);
        chk("rst_write", btb_write, 0);
        chk("rst_flush", flush, 0);
        chk("rst_err", err, 0);
        chk("rst_key", btb_key, 0);
        chk("rst_cnt", dut.cnt[3], 2'b01);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_reset();
            set_push(vecs[i].pc, vecs[i].tgt, vecs[i].ptk);
            step();
            set_res(vecs[i].rtk, vecs[i].rtgt);
            step();
            chk($sformatf("v%0d_write", i), btb_write, vecs[i].w);
            chk($sformatf("v%0d_key", i), btb_key, vecs[i].k);
            chk($sformatf("v%0d_val", i), btb_val, vecs[i].v);
            chk($sformatf("v%0d_hit", i), btb_hit, vecs[i].h);
            chk($sformatf("v%0d_flush", i), flush, vecs[i].f);
            chk($sformatf("v%0d_redirect", i), redirect, vecs[i].r);
            chk($sformatf("v%0d_count", i), dut.u_fifo.count, 0);
            step();
            chk($sformatf("v%0d_write_drop", i), btb_write, 0);
            chk($sformatf("v%0d_flush_drop", i), flush, 0);
            chk($sformatf("v%0d_key_hold", i), btb_key, vecs[i].k);
        end

        // mispredict with a younger entry queued and a push in the same cycle
        do_reset();
        set_push(16'h0020, 16'h0000, 1'b0);
        step();
        set_push(16'h0021, 16'h0090, 1'b1);
        step();
        chk("mp_count_pre", dut.u_fifo.count, 2);
        set_push(16'h0022, 16'h0091, 1'b1);
        set_res(1'b1, 16'h0080);
        step();
        chk("mp_flush", flush, 1);
        chk("mp_redirect", redirect, 16'h0080);
        chk("mp_count", dut.u_fifo.count, 0);
        chk("mp_ready", pred_ready, 1);

        // full queue, 5th push dropped despite simultaneous pop
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            set_push(16'(i), 16'(16'h0100 + i), 1'b1);
            step();
        end
        chk("full_ready", pred_ready, 0);
        chk("full_count", dut.u_fifo.count, 4);
        set_push(16'h0005, 16'h0105, 1'b1);
        set_res(1'b1, 16'h0101);
        step();
        chk("full_count_after", dut.u_fifo.count, 3);
        chk("full_key1", btb_key, 16'h0001);
        chk("full_ready_after", pred_ready, 1);
        for (int i = 2; i <= 4; i++) begin
            set_res(1'b1, 16'(16'h0100 + i));
            step();
            chk($sformatf("full_key%0d", i), btb_key, 16'(i));
            chk($sformatf("full_flush%0d", i), flush, 0);
        end
        set_res(1'b1, 16'h0105);
        step();
        chk("full_fifth_absent", btb_write, 0);
        chk("full_fifth_err", err, 1);

        // resolve on empty queue
        do_reset();
        set_res(1'b1, 16'h0040);
        step();
        chk("empty_write", btb_write, 0);
        chk("empty_flush", flush, 0);
        chk("empty_err", err, 1);
        chk("empty_cnt", dut.cnt[0], 2'b01);
        step();
        step();
        chk("empty_err_sticky", err, 1);
        reset = 1'b0;
        #1;
        chk("empty_err_cleared", err, 0);
        @(negedge clk);
        reset = 1'b1;

        // counter saturation then asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_push(16'h0018, 16'h0060, 1'b1);
            step();
            set_res(1'b1, 16'h0060);
            step();
            chk($sformatf("sat_hit%0d", i), btb_hit, 1);
            chk($sformatf("sat_write%0d", i), btb_write, 1);
            chk($sformatf("sat_cnt%0d", i), dut.cnt[0], (i == 0) ? 2'b10 : 2'b11);
        end
        #2;
        reset = 1'b0;
        #1;
        chk("arst_write", btb_write, 0);
        chk("arst_key", btb_key, 0);
        chk("arst_val", btb_val, 0);
        chk("arst_hit", btb_hit, 0);
        chk("arst_flush", flush, 0);
        chk("arst_redirect", redirect, 0);
        chk("arst_cnt", dut.cnt[0], 2'b01);
        @(negedge clk);
        reset = 1'b1;
        set_push(16'h0018, 16'h0060, 1'b1);
        step();
        chk("first_push_after_reset", dut.u_fifo.count, 1);
        chk("no_stale_write", btb_write, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
